// File: rtl/switch_ingress_arbiter.sv
// switch_ingress_arbiter: round-robin frame arbiter onto the switch fabric; ARB_WATCHDOG_EN adds a stall watchdog
module switch_ingress_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W = 8
`ifdef ARB_WATCHDOG_EN
  ,
  parameter int WDT_CYCLES = 64
`endif
) (
  input  logic                        FPGA_CLK,
  input  logic                        FPGA_RST_BTN,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data,
  input  logic [NUM_PORTS-1:0]        req_last,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic                        fab_valid,
  output logic [DATA_W-1:0]           fab_data,
  output logic                        fab_last,
  output logic [1:0]                  fab_src,
  input  logic                        fab_ready,
  output logic [NUM_PORTS-1:0]        grant,
  output logic                        busy,
  output logic [7:0]                  frame_cnt,
  output logic                        wdt_abort
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d, pick;
  logic [1:0] rr_ptr_q, rr_ptr_d, src;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic xfer, done, abort;
  // scan downwards so the port nearest after rr_ptr wins
  always_comb begin
    pick = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_PORTS]) begin
        pick = '0;
        pick[(int'(rr_ptr_q) + k) % NUM_PORTS] = 1'b1;
      end
    end
  end
  always_comb begin
    fab_data = '0;
    src = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      fab_data = fab_data | (grant_q[i] ? req_data[i*DATA_W +: DATA_W] : '0);
      src = src | (grant_q[i] ? 2'(i) : 2'd0);
    end
  end
  assign fab_valid = |(req_valid & grant_q);
  assign fab_last  = |(req_last & grant_q);
  assign req_ready = grant_q & {NUM_PORTS{fab_ready}};
  assign fab_src   = src;
  assign grant     = grant_q;
  assign busy      = state_q == XFER;
  assign frame_cnt = frame_cnt_q;
  assign xfer      = fab_valid & fab_ready;
  assign done      = xfer & fab_last;
`ifdef ARB_WATCHDOG_EN
  localparam int SW = $clog2(WDT_CYCLES) + 1;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic wdt_abort_q, wdt_abort_d;
  assign abort       = state_q == XFER && !xfer && stall_cnt_q == SW'(WDT_CYCLES - 1);
  assign wdt_abort_d = abort;
  assign stall_cnt_d = (state_q != XFER || xfer || abort) ? '0 : stall_cnt_q + 1'b1;
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
    if (!FPGA_RST_BTN) begin
      stall_cnt_q <= '0;
      wdt_abort_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      wdt_abort_q <= wdt_abort_d;
    end
  end
  assign wdt_abort = wdt_abort_q;
`else
  assign abort     = 1'b0;
  assign wdt_abort = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    frame_cnt_d = frame_cnt_q;
    if (state_q == IDLE) begin
      if (|req_valid) begin
        state_d = XFER;
        grant_d = pick;
      end
    end else if (done || abort) begin
      state_d = IDLE;
      grant_d = '0;
      rr_ptr_d = src;
      frame_cnt_d = done ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end
  end
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
    if (!FPGA_RST_BTN) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= 2'(NUM_PORTS - 1);
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
endmodule

// File: doc/switch_ingress_arbiter.md
Name: switch_ingress_arbiter

Overview:
Round-robin arbiter sharing the single L2 switch fabric input among the four node transmitters (A, B, C, D on ports 0..3).
- Each node presents multi-beat frames as a valid/ready stream: beat 0 = {DST[7:4], SRC[3:0]}, then payload beats, with last marking the final beat.
- The arbiter grants one port per frame and muxes that port's stream onto the fabric.
- It sits between the node frame generators and the switch core inside the FPGA simulator top.

Parameters:
NUM_PORTS, 4, number of requesting node ports
DATA_W, 8, beat width in bits
WDT_CYCLES, 64, stall cycles in a granted frame before forced abort (used only with the optional feature)

Ports:
FPGA_CLK  in  1  system clock
FPGA_RST_BTN  in  1  asynchronous active-low reset
req_valid  in  NUM_PORTS  per-port beat valid
req_data  in  NUM_PORTS*DATA_W  per-port beat data; port i at [i*DATA_W +: DATA_W]
req_last  in  NUM_PORTS  per-port last-beat flag
req_ready  out  NUM_PORTS  per-port beat accepted
fab_valid  out  1  fabric beat valid
fab_data  out  DATA_W  fabric beat data
fab_last  out  1  fabric last-beat flag
fab_src  out  2  index of the granted port
fab_ready  in  1  fabric accepts beat
grant  out  NUM_PORTS  one-hot registered grant; zero when idle
busy  out  1  high while in XFER
frame_cnt  out  8  completed frames, wraps 255->0
wdt_abort  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset is asynchronous and active-low. While FPGA_RST_BTN=0:
  - state=IDLE, grant=0, rr_ptr=NUM_PORTS-1 so that port 0 has first priority.
  - frame_cnt=0, stall_cnt=0, wdt_abort=0.
  - fab_valid, fab_last, req_ready are all 0 immediately, because they derive combinationally from grant=0.
  - fab_data=0, fab_src=0.
- State IDLE:
  - If any req_valid is high, pick the first asserted port searching rr_ptr+1, rr_ptr+2, … modulo NUM_PORTS.
  - On the next edge, register the one-hot grant and go to XFER.
  - No beat is accepted in IDLE.
- State XFER, granted port g, all combinational:
  - fab_valid=req_valid[g], fab_data=req_data[g], fab_last=req_last[g], fab_src=g.
  - req_ready[g]=fab_ready; all other req_ready bits are 0.
  - A beat transfers when fab_valid & fab_ready.
- Latency:
  - req_valid rising in cycle n → grant and fab_valid in cycle n+1 (assuming IDLE).
  - There is one mandatory IDLE cycle between back-to-back frames.
- End of frame: a transfer with fab_last=1 causes, on that edge:
  - state→IDLE, grant→0, rr_ptr→g;
  - frame_cnt increments (modulo 256).
- Holding the grant:
  - A granted port that deasserts req_valid mid-frame keeps the grant; there is no re-arbitration until last.
  - Requests from other ports are ignored during XFER.
- Fairness: with all four ports continuously requesting, the grant order is 0,1,2,3,0,… Every requester is granted within NUM_PORTS frames.
- Single-beat frame (last on beat 0): valid; one transfer, then IDLE.
- fab_ready low in XFER: the beat is held, req_ready is low, and nothing changes.
- busy=1 exactly while state=XFER.
- Reset asserted mid-frame: the frame is dropped immediately and no frame_cnt increment occurs. After release, arbitration restarts with port 0 first.

Optional Feature:
Macro: ARB_WATCHDOG_EN
- With ARB_WATCHDOG_EN defined:
  - In XFER, stall_cnt increments every cycle with no beat transfer and clears on any transfer or on entering XFER.
  - When stall_cnt reaches WDT_CYCLES-1 without a transfer, the next edge causes:
    - grant→0, state→IDLE, rr_ptr→g;
    - wdt_abort=1 for one cycle; frame_cnt is not incremented.
  - The abandoned port must restart its frame from beat 0.
- Without ARB_WATCHDOG_EN:
  - No stall_cnt is built; wdt_abort is tied 0.
  - The grant is held indefinitely until last transfers.

Test Plan:
1. Reset, then port 0 (node A) sends the 3-beat frame 8'hCA,8'h05,8'h0F(last) with fab_ready=1 → grant=0001 one cycle after req_valid; fab_data sequence CA,05,0F with fab_src=0; fab_last on the third beat; grant=0 and frame_cnt=1 afterwards.
2. All four ports request 2-beat frames continuously with fab_ready=1 → grants 0001,0010,0100,1000,0001 with one IDLE cycle between frames; frame_cnt=4 after the fourth frame.
3. Port 2 granted; fab_ready held low for 10 cycles mid-frame → fab_data held stable, req_ready[2]=0, grant unchanged; frame completes normally once fab_ready=1.
4. Port 1 granted; it drops req_valid for 5 cycles after beat 0 while port 3 requests → grant stays 0010, fab_valid=0 during the gap; port 3 is granted only after port 1's last beat.
5. Reset asserted while port 0 is mid-frame → grant, fab_valid, req_ready go to 0 asynchronously; frame_cnt unchanged. After release with ports 0 and 2 requesting, port 0 is granted first.
6. With ARB_WATCHDOG_EN and WDT_CYCLES=8: port 1 stalls (req_valid=0) for 8 cycles after beat 0 → wdt_abort pulses once, grant→0, frame_cnt unchanged, and a waiting port 2 is granted next. Without the macro, the grant is still 0010 after 100 cycles.
